// File: rtl/div_seq_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// div_seq_unit
//   Sequential restoring divider. It produces one quotient bit per clock.
//   After a start is accepted the unit spends one LOAD cycle, then WIDTH CALC
//   cycles, then pulses done for one cycle in DONE. A zero divisor
//   short-circuits from LOAD straight to DONE. Results are held in output
//   registers, so intermediate values of the iteration are never visible.
//
//   Optional feature: define DIV_SIGNED_EN to add two's-complement division.
//   This adds the signed_mode input and a one-cycle FIX state, which fixes
//   up the signs after an unsigned magnitude division.
//
// Parameters
//   WIDTH        operand / result width in bits (4..32), default 16
//
// Ports
//   clk          clock; all state changes on its rising edge
//   reset_a_n    asynchronous active-low reset; abandons any division
//   start        request, accepted in IDLE or DONE
//   dividend     numerator, captured on accept
//   divisor      denominator, captured on accept
//   signed_mode  (DIV_SIGNED_EN only) treat the operands as signed
//   busy         high in LOAD, CALC and FIX
//   done         one-cycle pulse; the results are valid from this cycle
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag for the last completed result
//   err          high for any cycle in which start is seen while busy
// ---------------------------------------------------------------------------
module div_seq_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_a_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             err
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
`ifdef DIV_SIGNED_EN
        S_FIX,
`endif
        S_DONE
    } state_t;

    state_t           state_q, state_d;

    // Captured operands. In LOAD, dvs_q is replaced by its magnitude.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    // Working registers of the restoring iteration: the partial remainder,
    // and the shift register that starts as the dividend and ends as the
    // quotient.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Output registers. They only change when a result is committed.
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // Magnitudes used to seed the iteration.
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
    logic             smode_q, smode_d;
    logic             qneg_q, qneg_d;   // quotient must be negated in FIX
    logic             rneg_q, rneg_d;   // remainder takes the dividend's sign
    logic             dvd_neg, dvs_neg;

    assign dvd_neg = smode_q & dvd_q[WIDTH-1];
    assign dvs_neg = smode_q & dvs_q[WIDTH-1];
    // The most-negative value maps to itself, which is its correct unsigned
    // magnitude, so most-negative / -1 needs no special case.
    assign dvd_mag = dvd_neg ? ('0 - dvd_q) : dvd_q;
    assign dvs_mag = dvs_neg ? ('0 - dvs_q) : dvs_q;
`else
    assign dvd_mag = dvd_q;
    assign dvs_mag = dvs_q;
`endif

    // One restoring step. Shift {rem,quo} left by one, then trial-subtract
    // the divisor over WIDTH+1 bits, so the bit shifted out of rem is kept.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   kept;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             unused_kept_msb;

    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign fits     = (rem_sh >= {1'b0, dvs_q});
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign kept     = fits ? trial : rem_sh;
    // The kept value is always below the divisor, so its top bit is zero.
    assign rem_step = kept[WIDTH-1:0];
    assign unused_kept_msb = kept[WIDTH];
    assign quo_step = {quo_q[WIDTH-2:0], fits};

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            smode_q     <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            smode_q     <= smode_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        smode_d     = smode_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
`ifdef DIV_SIGNED_EN
                    smode_d = signed_mode;
`endif
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    cnt_d   = '0;
`ifdef DIV_SIGNED_EN
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
`endif
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    quotient_d  = quo_step;
                    remainder_d = rem_step;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
`ifdef DIV_SIGNED_EN
                    // Signed results are committed by FIX, so the outputs
                    // keep their old values for one more cycle.
                    if (smode_q) begin
                        quotient_d  = quotient_q;
                        remainder_d = remainder_q;
                        dbz_d       = dbz_q;
                        state_d     = S_FIX;
                    end
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            S_FIX: begin
                quotient_d  = qneg_q ? ('0 - quo_q) : quo_q;
                remainder_d = rneg_q ? ('0 - rem_q) : rem_q;
                dbz_d       = 1'b0;
                state_d     = S_DONE;
            end
`endif

            S_DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
`ifdef DIV_SIGNED_EN
                    smode_d = signed_mode;
`endif
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = !((state_q == S_IDLE) || (state_q == S_DONE));
    assign done        = (state_q == S_DONE);
    assign err         = start && busy;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_unit.sv
`timescale 1ns/1ps
module tb_div_seq_unit;

    localparam int W   = 16;
    localparam int LIM = W + 12;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;   // cycle of done, counting the LOAD cycle as 1
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_a_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic         signed_mode;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] hold_q;

    always #5 clk = ~clk;

    div_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_a_n   (reset_a_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer division, with SV's truncating signed
    // semantics, done in a wide type and truncated back to W bits.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        vec_t v;
        v.a = a;
        v.b = b;
        v.sm = sm;
        if (b == '0) begin
            v.q = '1;
            v.r = a;
            v.dbz = 1'b1;
            v.lat = 2;
        end else begin
            v.dbz = 1'b0;
            v.lat = W + 2;
            v.q = a / b;
            v.r = a % b;
`ifdef DIV_SIGNED_EN
            if (sm) begin
                longint sa, sb;
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                v.q = W'(sa / sb);
                v.r = W'(sa % sb);
                v.lat = W + 3;
            end
`endif
        end
        return v;
    endfunction

    // Drive a request, let the next rising edge accept it, then drop start.
    // The task returns #1 into the LOAD cycle.
    task automatic apply_start(input vec_t v);
        dividend = v.a;
        divisor  = v.b;
`ifdef DIV_SIGNED_EN
        signed_mode = v.sm;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sample at each falling edge until done is seen. lat = 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= LIM; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        apply_start(v);
        wait_done(lat);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " quotient"}, quotient, v.q);
        chk({tag, " remainder"}, remainder, v.r);
        chk({tag, " div_by_zero"}, div_by_zero, v.dbz);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 1'b0);
        hold_q = v.q;
    endtask

    vec_t vecs[$];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;
        vec_t v;
        logic [W-1:0] ra, rb;
        logic rsm;
        int sel;

        reset_a_n = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef DIV_SIGNED_EN
        signed_mode = 1'b0;
`endif
        hold_q = '0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset err", err, 1'b0);
        chk("reset quotient", quotient, '0);
        chk("reset remainder", remainder, '0);
        chk("reset div_by_zero", div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        reset_a_n = 1'b1;
        @(negedge clk);

        // Directed vectors: {a, b, signed, q, r, dbz, latency}
        vecs.push_back('{16'd1000,  16'd7,     1'b0, 16'd142,   16'd6,    1'b0, 18});
        vecs.push_back('{16'hFFFF,  16'h0001,  1'b0, 16'hFFFF,  16'd0,    1'b0, 18});
        vecs.push_back('{16'd5,     16'd9,     1'b0, 16'd0,     16'd5,    1'b0, 18});
        vecs.push_back('{16'd1234,  16'd0,     1'b0, 16'hFFFF,  16'd1234, 1'b1, 2});
        vecs.push_back('{16'd0,     16'd5,     1'b0, 16'd0,     16'd0,    1'b0, 18});
        vecs.push_back('{16'hFFFF,  16'hFFFF,  1'b0, 16'd1,     16'd0,    1'b0, 18});
        vecs.push_back('{16'h8000,  16'd3,     1'b0, 16'd10922, 16'd2,    1'b0, 18});
        vecs.push_back('{16'd0,     16'd0,     1'b0, 16'hFFFF,  16'd0,    1'b1, 2});
        vecs.push_back('{16'hFF9C,  16'd7,     1'b0, 16'd9348,  16'd0,    1'b0, 18});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{16'hFF9C,  16'd7,     1'b1, 16'hFFF2,  16'hFFFE, 1'b0, 19});
        vecs.push_back('{16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'd0,    1'b0, 19});
        vecs.push_back('{16'd100,   16'hFFF9,  1'b1, 16'hFFF2,  16'd2,    1'b0, 19});
        vecs.push_back('{16'hFF9C,  16'hFFF9,  1'b1, 16'd14,    16'hFFFE, 1'b0, 19});
        vecs.push_back('{16'hFF9C,  16'd0,     1'b1, 16'hFFFF,  16'hFF9C, 1'b1, 2});
`endif
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // start during CALC raises err, is ignored, and does not disturb
        // the running division; a start in DONE chains the next one.
        apply_start('{16'd50000, 16'd123, 1'b0, 16'd406, 16'd62, 1'b0, 18});
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        chk("busy_start err", err, 1'b1);
        chk("busy_start busy", busy, 1'b1);
        chk("busy_start no partial", quotient, hold_q);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_start err drop", err, 1'b0);
        wait_done(lat);
        chk("busy_start latency", (lat == 0) ? 0 : lat + 7, 18);
        chk("busy_start quotient", quotient, 16'd406);
        chk("busy_start remainder", remainder, 16'd62);
        dividend = 16'd5;
        divisor  = 16'd9;
        start    = 1'b1;
        #1;
        chk("b2b no err in DONE", err, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b done single", done, 1'b0);
        chk("b2b busy", busy, 1'b1);
        wait_done(lat);
        chk("b2b latency", (lat == 0) ? 0 : lat + 1, 18);
        chk("b2b quotient", quotient, 16'd0);
        chk("b2b remainder", remainder, 16'd5);
        @(negedge clk);

        // Reset in the middle of CALC.
        run_vec('{16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1, 2}, "pre_rst");
        apply_start('{16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0, 18});
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mid busy", busy, 1'b1);
        chk("mid quotient held", quotient, 16'hFFFF);
        reset_a_n = 1'b0;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst quotient", quotient, '0);
        chk("rst remainder", remainder, '0);
        chk("rst div_by_zero", div_by_zero, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_a_n = 1'b1;
        @(negedge clk);
        run_vec('{16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0, 18}, "post_rst");

        // Random operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            ra  = W'($urandom);
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      rb = '0;
            else if (sel < 6)  rb = W'($urandom_range(1, 15));
            else               rb = W'($urandom);
`ifdef DIV_SIGNED_EN
            rsm = 1'($urandom_range(0, 1));
`else
            rsm = 1'b0;
`endif
            v = model(ra, rb, rsm);
            run_vec(v, $sformatf("rand%0d %0h/%0h", n, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_seq_unit.md
DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_a_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled on the rising edge of clk.
REQ-005 dividend  input  WIDTH  numerator; captured when start is accepted.
REQ-006 divisor  input  WIDTH  denominator; captured when start is accepted.
REQ-007 busy  output  1  high while a division is in progress (LOAD, CALC, FIX).
REQ-008 done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 quotient  output  WIDTH  registered quotient.
REQ-010 remainder  output  WIDTH  registered remainder.
REQ-011 div_by_zero  output  1  registered flag; set for the result just completed.
REQ-012 err  output  1  one-cycle pulse when start is asserted while busy.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, CALC, FIX and DONE; FIX exists only under DIV_SIGNED_EN.
REQ-014 IDLE or DONE with start=1 SHALL capture the operands and go to LOAD; with start=0, DONE SHALL return to IDLE.
REQ-015 LOAD with divisor==0 SHALL go to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
REQ-016 LOAD with a non-zero divisor SHALL clear the partial remainder and iteration counter, then go to CALC.
REQ-017 Each CALC cycle SHALL perform one restoring step: shift {rem,quo} left by one, trial-subtract the divisor, keep the difference and set the quotient LSB when the difference is non-negative, otherwise restore and clear the LSB.
REQ-018 CALC SHALL last exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter, then go to DONE (or to FIX).
REQ-019 The trial subtraction SHALL be WIDTH+1 bits wide so no carry is lost at any WIDTH.
REQ-020 Unsigned latency SHALL be fixed: done is high WIDTH+2 cycles after the accepting edge; divide-by-zero results complete 2 cycles after it.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next LOAD.
REQ-022 start during LOAD, CALC or FIX SHALL be ignored for operand capture and SHALL raise err for that cycle; the division in progress continues.
REQ-023 start in the DONE cycle SHALL be accepted (back-to-back operation); done still pulses for the completed result.
REQ-024 busy SHALL be low in IDLE and DONE.

Reset
REQ-025 Asserting reset_a_n low SHALL force IDLE immediately, including in the middle of a division, and abandon that operation.
REQ-026 Reset values: busy=0, done=0, err=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
REQ-027 After release, the first accepted start SHALL behave as after power-up; no partial result SHALL be visible.

Configuration
REQ-028 Macro DIV_SIGNED_EN SHALL add input signed_mode (1 bit, captured together with the operands).
REQ-029 With DIV_SIGNED_EN and signed_mode=1:
- LOAD SHALL take the magnitudes of both operands.
- FIX (one cycle) SHALL negate the quotient when the operand signs differ.
- FIX SHALL give the remainder the sign of the dividend.
- Latency SHALL become WIDTH+3.
REQ-030 With DIV_SIGNED_EN, most-negative / -1 SHALL return quotient=most-negative and remainder=0, with no error flag.
REQ-031 With DIV_SIGNED_EN and signed_mode=0, the FSM SHALL skip FIX and behave exactly as the unsigned build.
REQ-032 Without DIV_SIGNED_EN, there SHALL be no signed_mode port, no FIX state and no signed logic.

Verification (WIDTH=16)
REQ-033 start with 1000/7 -> done exactly 18 cycles later; quotient=142, remainder=6, div_by_zero=0.
REQ-034 start with 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0; then 5/9 -> quotient=0, remainder=5.
REQ-035 start with 1234/0 -> done 2 cycles later; quotient=0xFFFF, remainder=1234, div_by_zero=1.
REQ-036 start re-asserted on CALC cycle 5 -> err pulses once; the original result is unchanged; a start in the DONE cycle begins the next division.
REQ-037 reset_a_n low on CALC cycle 8 -> all outputs 0 and IDLE within that cycle; the next start returns a correct result.
REQ-038 DIV_SIGNED_EN, signed_mode=1, -100/7 -> quotient=-14, remainder=-2, done at 19 cycles; 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
